rv_multicycle_ctrl: RTL

//  Control FSM for the multi-cycle RV32I core. Replaces the single-cycle CU/complete_bit scheme.

---
 rtl/rv_ctrl_pkg.sv | 71 +++++++
 rtl/rv_ctrl_decode.sv | 62 ++++++
 rtl/rv_multicycle_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states,
// opcode values, datapath select codes, halt causes and the decode record.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Datapath select encodings
  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_IMM     = 2'd1;
  localparam logic [1:0] PC_ALU     = 2'd2;
  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;
  localparam logic       ALU_B_RS2  = 1'b0;
  localparam logic       ALU_B_IMM  = 1'b1;
  localparam logic [1:0] ALU_OP_ADD = 2'd0;
  localparam logic [1:0] ALU_OP_FN  = 2'd1;
  localparam logic [1:0] ALU_OP_BR  = 2'd2;
  localparam logic [2:0] IMM_I      = 3'd0;
  localparam logic [2:0] IMM_S      = 3'd1;
  localparam logic [2:0] IMM_B      = 3'd2;
  localparam logic [2:0] IMM_U      = 3'd3;
  localparam logic [2:0] IMM_J      = 3'd4;
  localparam logic [1:0] WB_ALU     = 2'd0;
  localparam logic [1:0] WB_MEM     = 2'd1;
  localparam logic [1:0] WB_PC4     = 2'd2;

  // Halt causes
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  // Everything the FSM needs to know about one opcode
  typedef struct packed {
    logic       legal;
    logic       is_sys;
    logic       is_mem;
    logic       is_store;
    logic       is_branch;
    logic       writes_rd;
    logic [1:0] pc_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op_sel;
    logic [2:0] imm_sel;
    logic [1:0] wb_sel;
  } dec_t;

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational opcode decoder: maps a 7-bit major opcode to its control record.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output dec_t       dec_o
);

  // Opcode lookup; unknown opcodes leave legal=0 so the FSM halts on them
  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OPC_LUI: begin
        dec_o.legal = 1'b1; dec_o.writes_rd = 1'b1;
        dec_o.alu_a_sel = ALU_A_ZERO; dec_o.alu_b_sel = ALU_B_IMM; dec_o.imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        dec_o.legal = 1'b1; dec_o.writes_rd = 1'b1;
        dec_o.alu_a_sel = ALU_A_PC; dec_o.alu_b_sel = ALU_B_IMM; dec_o.imm_sel = IMM_U;
      end
      OPC_JAL: begin
        dec_o.legal = 1'b1; dec_o.writes_rd = 1'b1; dec_o.pc_sel = PC_IMM;
        dec_o.alu_a_sel = ALU_A_PC; dec_o.alu_b_sel = ALU_B_IMM; dec_o.imm_sel = IMM_J;
        dec_o.wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        dec_o.legal = 1'b1; dec_o.writes_rd = 1'b1; dec_o.pc_sel = PC_ALU;
        dec_o.alu_b_sel = ALU_B_IMM; dec_o.imm_sel = IMM_I; dec_o.wb_sel = WB_PC4;
      end
      OPC_BRANCH: begin
        dec_o.legal = 1'b1; dec_o.is_branch = 1'b1;
        dec_o.alu_b_sel = ALU_B_RS2; dec_o.alu_op_sel = ALU_OP_BR; dec_o.imm_sel = IMM_B;
      end
      OPC_LOAD: begin
        dec_o.legal = 1'b1; dec_o.writes_rd = 1'b1; dec_o.is_mem = 1'b1;
        dec_o.alu_b_sel = ALU_B_IMM; dec_o.imm_sel = IMM_I; dec_o.wb_sel = WB_MEM;
      end
      OPC_STORE: begin
        dec_o.legal = 1'b1; dec_o.is_mem = 1'b1; dec_o.is_store = 1'b1;
        dec_o.alu_b_sel = ALU_B_IMM; dec_o.imm_sel = IMM_S;
      end
      OPC_OPIMM: begin
        dec_o.legal = 1'b1; dec_o.writes_rd = 1'b1;
        dec_o.alu_b_sel = ALU_B_IMM; dec_o.alu_op_sel = ALU_OP_FN; dec_o.imm_sel = IMM_I;
      end
      OPC_OP: begin
        dec_o.legal = 1'b1; dec_o.writes_rd = 1'b1;
        dec_o.alu_b_sel = ALU_B_RS2; dec_o.alu_op_sel = ALU_OP_FN;
      end
      OPC_FENCE: begin
        dec_o.legal = 1'b1;
      end
      OPC_SYSTEM: begin
        dec_o.legal = 1'b1; dec_o.is_sys = 1'b1;
      end
      default: begin
        dec_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over one
// shared memory port, drives datapath enables/selects, counts retired
// instructions and halts stickily on SYSTEM, illegal opcode or memory timeout.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int CNT_W        = XLEN,
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [31:0]      instr_i,
  input  logic             mem_ready_i,
  input  logic             br_taken_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             addr_sel_o,
  output logic             ir_we_o,
  output logic             rf_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_sel_o,
  output logic [1:0]       alu_a_sel_o,
  output logic             alu_b_sel_o,
  output logic [1:0]       alu_op_sel_o,
  output logic [2:0]       imm_sel_o,
  output logic [1:0]       wb_sel_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retired_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic [1:0]       cause_o
);

  // Counter only needs to reach MEM_WAIT_MAX-1
  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_e            state_q, state_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [1:0]        cause_q, cause_d;

  logic [6:0] dec_opc_s;
  dec_t       dec_s;
  logic       mem_phase_s;
  logic       timeout_s;
  logic       unused_instr_s;

  // During DECODE the opcode register is not loaded yet, so decode the bus directly
  assign dec_opc_s   = (state_q == ST_DECODE) ? instr_i[6:0] : opcode_q;
  assign mem_phase_s = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timeout_s   = mem_phase_s && !mem_ready_i && (wait_q == WAIT_LAST);
  assign unused_instr_s = ^instr_i[31:12];

  rv_ctrl_decode u_decode (
    .opcode_i (dec_opc_s),
    .dec_o    (dec_s)
  );

  // Next-state, halt cause and all datapath controls; outputs default to 0
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    addr_sel_o   = 1'b0;
    ir_we_o      = 1'b0;
    rf_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_sel_o     = PC_PLUS4;
    alu_a_sel_o  = ALU_A_RS1;
    alu_b_sel_o  = ALU_B_RS2;
    alu_op_sel_o = ALU_OP_ADD;
    imm_sel_o    = IMM_I;
    wb_sel_o     = WB_ALU;
    retire_o     = 1'b0;
    busy_o       = 1'b0;
    halted_o     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_FETCH: begin
        busy_o    = 1'b1;
        mem_req_o = 1'b1;
        ir_we_o   = mem_ready_i;
        if (mem_ready_i) begin
          state_d = ST_DECODE;
        end else if (timeout_s) begin
          state_d = ST_HALT;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        busy_o = 1'b1;
        if (!dec_s.legal) begin
          state_d = ST_HALT;
          cause_d = CAUSE_ILLEGAL;
        end else if (dec_s.is_sys) begin
          state_d = ST_HALT;
          cause_d = CAUSE_SYSTEM;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy_o       = 1'b1;
        alu_a_sel_o  = dec_s.alu_a_sel;
        alu_b_sel_o  = dec_s.alu_b_sel;
        alu_op_sel_o = dec_s.alu_op_sel;
        imm_sel_o    = dec_s.imm_sel;
        if (dec_s.is_mem) state_d = ST_MEM;
        else              state_d = ST_WB;
      end
      ST_MEM: begin
        busy_o       = 1'b1;
        mem_req_o    = 1'b1;
        addr_sel_o   = 1'b1;
        mem_we_o     = dec_s.is_store;
        alu_a_sel_o  = dec_s.alu_a_sel;
        alu_b_sel_o  = dec_s.alu_b_sel;
        alu_op_sel_o = dec_s.alu_op_sel;
        imm_sel_o    = dec_s.imm_sel;
        if (mem_ready_i) begin
          state_d = ST_WB;
        end else if (timeout_s) begin
          state_d = ST_HALT;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        busy_o       = 1'b1;
        pc_we_o      = 1'b1;
        retire_o     = 1'b1;
        rf_we_o      = dec_s.writes_rd && (instr_i[11:7] != 5'd0);
        pc_sel_o     = dec_s.is_branch ? {1'b0, br_taken_i} : dec_s.pc_sel;
        wb_sel_o     = dec_s.wb_sel;
        alu_a_sel_o  = dec_s.alu_a_sel;
        alu_b_sel_o  = dec_s.alu_b_sel;
        alu_op_sel_o = dec_s.alu_op_sel;
        imm_sel_o    = dec_s.imm_sel;
        if (run_i) state_d = ST_FETCH;
        else       state_d = ST_IDLE;
      end
      ST_HALT: begin
        halted_o = 1'b1;
        state_d  = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Opcode capture, memory wait count and retire count
  always_comb begin
    opcode_d = (state_q == ST_DECODE) ? instr_i[6:0] : opcode_q;
    if (mem_phase_s && !mem_ready_i) wait_d = wait_q + WAIT_W'(1);
    else                             wait_d = '0;
    if (state_q == ST_WB) retired_d = retired_q + CNT_W'(1);
    else                  retired_d = retired_q;
  end

  // State and bookkeeping registers with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      opcode_q  <= 7'd0;
      wait_q    <= '0;
      retired_q <= '0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
    end
  end

  assign retired_o = retired_q;
  assign cause_o   = cause_q;

endmodule
